// File: rtl/ft64_bmat_pkg.sv
// Shared types and constants for the FT64 8x8 GF(2) bit-matrix inverter.
// Provides the matrix packing helper, the identity constant, the state enum and a GF(2) product.
package ft64_bmat_pkg;

  localparam int N   = 7;
  localparam int DIM = N + 1;
  localparam int DBW = DIM * DIM;

  localparam logic [DBW-1:0] IDENT = 64'h8040201008040201;

  typedef enum logic [1:0] {
    IDLE,
    ELIM,
    CHK,
    DONE
  } state_e;

  // Row vector with bit j holding column j.
  typedef logic [DIM-1:0]         row_t;
  typedef logic [$clog2(DIM)-1:0] idx_t;

  function automatic logic [5:0] bidx(input int i, input int j);
    return 6'((N - i) * DIM + (N - j));
  endfunction

  function automatic logic [DBW-1:0] gf2_mul(
    input logic [DBW-1:0] x,
    input logic [DBW-1:0] y
  );
    logic [DBW-1:0] p;
    logic           acc;
    p = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        acc = 1'b0;
        for (int k = 0; k < DIM; k++) begin
          acc = acc ^ (x[bidx(i, k)] & y[bidx(k, j)]);
        end
        p[bidx(i, j)] = acc;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ft64_bmat_elim_step.sv
// One Gauss-Jordan column step over GF(2): pivot search, row swap, row XOR.
// Ports: l_i/r_i working matrices, col_i column, l_o/r_o next matrices, found_o pivot exists.
module ft64_bmat_elim_step
  import ft64_bmat_pkg::*;
(
  input  logic [DBW-1:0] l_i,
  input  logic [DBW-1:0] r_i,
  input  idx_t           col_i,
  output logic [DBW-1:0] l_o,
  output logic [DBW-1:0] r_o,
  output logic           found_o
);

  row_t lr [DIM];
  row_t rr [DIM];
  row_t ls [DIM];
  row_t rs [DIM];
  idx_t piv;

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        lr[i][j] = l_i[bidx(i, j)];
        rr[i][j] = r_i[bidx(i, j)];
      end
    end

    // Downward loop leaves the lowest qualifying row as pivot.
    found_o = 1'b0;
    piv     = col_i;
    for (int i = N; i >= 0; i--) begin
      if (idx_t'(i) >= col_i && lr[i][col_i]) begin
        found_o = 1'b1;
        piv     = idx_t'(i);
      end
    end

    ls        = lr;
    rs        = rr;
    ls[col_i] = lr[piv];
    ls[piv]   = lr[col_i];
    rs[col_i] = rr[piv];
    rs[piv]   = rr[col_i];

    // Pivot row itself is never modified, so in-place update is safe.
    for (int r = 0; r < DIM; r++) begin
      if (idx_t'(r) != col_i && ls[r][col_i]) begin
        ls[r] = ls[r] ^ ls[col_i];
        rs[r] = rs[r] ^ rs[col_i];
      end
    end

    l_o = '0;
    r_o = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        l_o[bidx(i, j)] = ls[i][j];
        r_o[bidx(i, j)] = rs[i][j];
      end
    end
  end

endmodule

// File: rtl/ft64_bmat_inv.sv
// Sequential GF(2) inverter for a packed 8x8 bit matrix, one column per cycle.
// Ports: clk, rst (sync high), ld, a -> o, busy, done, singular, err. Self-check: FT64_BMINV_CHK_EN.
module ft64_bmat_inv
  import ft64_bmat_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [DBW-1:0] a,
  output logic [DBW-1:0] o,
  output logic           busy,
  output logic           done,
  output logic           singular,
  output logic           err
);

  state_e         state_q, state_d;
  logic [DBW-1:0] l_q, l_d;
  logic [DBW-1:0] r_q, r_d;
  logic [DBW-1:0] o_q, o_d;
  idx_t           col_q, col_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           sing_q, sing_d;

  logic [DBW-1:0] l_nx;
  logic [DBW-1:0] r_nx;
  logic           found;

`ifdef FT64_BMINV_CHK_EN
  logic [DBW-1:0] a_q, a_d;
  logic           err_q, err_d;
`endif

  ft64_bmat_elim_step u_step (
    .l_i     (l_q),
    .r_i     (r_q),
    .col_i   (col_q),
    .l_o     (l_nx),
    .r_o     (r_nx),
    .found_o (found)
  );

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    o_d     = o_q;
    col_d   = col_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sing_d  = sing_q;
`ifdef FT64_BMINV_CHK_EN
    a_d     = a_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (ld) begin
          state_d = ELIM;
          l_d     = a;
          r_d     = IDENT;
          col_d   = '0;
          o_d     = '0;
          sing_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef FT64_BMINV_CHK_EN
          a_d     = a;
          err_d   = 1'b0;
`endif
        end
      end
      ELIM: begin
        if (!found) begin
          sing_d  = 1'b1;
          o_d     = '0;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          l_d   = l_nx;
          r_d   = r_nx;
          col_d = col_q + 3'd1;
          if (col_q == idx_t'(N)) begin
            o_d = r_nx;
`ifdef FT64_BMINV_CHK_EN
            state_d = CHK;
`else
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end
      CHK: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef FT64_BMINV_CHK_EN
        err_d   = (gf2_mul(a_q, o_q) != IDENT);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      o_q     <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sing_q  <= 1'b0;
`ifdef FT64_BMINV_CHK_EN
      a_q     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      o_q     <= o_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sing_q  <= sing_d;
`ifdef FT64_BMINV_CHK_EN
      a_q     <= a_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o        = o_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign singular = sing_q;
`ifdef FT64_BMINV_CHK_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_ft64_bmat_inv.sv
// Self-checking bench for ft64_bmat_inv: transaction-level model, per-cycle compare.
// Randomized operands plus directed vectors; honours FT64_BMINV_CHK_EN for latency.
module tb_ft64_bmat_inv;

`ifdef FT64_BMINV_CHK_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif
  localparam logic [63:0] ID = 64'h8040201008040201;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld;
  logic [63:0] a;
  logic [63:0] o;
  logic        busy, done, singular, err;

  int n_chk  = 0;
  int n_fail = 0;

  ft64_bmat_inv dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .a        (a),
    .o        (o),
    .busy     (busy),
    .done     (done),
    .singular (singular),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  // Row i as a vector whose bit k is element (i,k).
  function automatic logic [7:0] getrow(input logic [63:0] m, input int i);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = m[63 - 8 * i - k];
    return r;
  endfunction

  // scol = first column linearly dependent on earlier ones (-1 if none);
  // inverse found by brute-force solving A x = e_j for each column j.
  function automatic void minv(input logic [63:0] m, output logic [63:0] inv,
                               output int scol);
    logic [7:0] rows [8];
    logic [7:0] basis [8];
    logic [7:0] v;
    logic       ins, ok, hit;
    inv  = '0;
    scol = -1;
    for (int i = 0; i < 8; i++) begin
      rows[i]  = getrow(m, i);
      basis[i] = '0;
    end
    for (int j = 0; j < 8; j++) begin
      if (scol < 0) begin
        for (int i = 0; i < 8; i++) v[i] = rows[i][j];
        ins = 1'b0;
        for (int b = 7; b >= 0; b--) begin
          if (!ins && v[b]) begin
            if (basis[b] == 0) begin
              basis[b] = v;
              ins      = 1'b1;
            end else begin
              v = v ^ basis[b];
            end
          end
        end
        if (!ins) scol = j;
      end
    end
    if (scol < 0) begin
      for (int j = 0; j < 8; j++) begin
        hit = 1'b0;
        for (int x = 0; x < 256; x++) begin
          if (!hit) begin
            ok = 1'b1;
            for (int i = 0; i < 8; i++)
              if ((^(rows[i] & 8'(x))) != (i == j)) ok = 1'b0;
            if (ok) begin
              hit = 1'b1;
              for (int k = 0; k < 8; k++) inv[63 - 8 * k - j] = x[k];
            end
          end
        end
      end
    end
  endfunction

  function automatic logic [63:0] mk_inv();
    logic [7:0] rw [8];
    logic [7:0] t;
    logic [63:0] m;
    int i, j;
    for (int k = 0; k < 8; k++) rw[k] = 8'h80 >> k;
    for (int n = 0; n < 24; n++) begin
      i = int'($urandom_range(7, 0));
      j = int'($urandom_range(7, 0));
      if (i != j) begin
        if ($urandom_range(1, 0) == 1) rw[i] = rw[i] ^ rw[j];
        else begin t = rw[i]; rw[i] = rw[j]; rw[j] = t; end
      end
    end
    for (int k = 0; k < 8; k++) m[63 - 8 * k -: 8] = rw[k];
    return m;
  endfunction

  // Transaction-level expectation, advanced on each active edge.
  logic        e_busy = 1'b0, e_done = 1'b0, e_s = 1'b0;
  logic [63:0] e_o = '0, res_o = '0;
  logic        res_s = 1'b0;
  int          cnt = 0;
  int          sc;

  always @(posedge clk) begin
    if (rst) begin
      e_busy = 1'b0; e_done = 1'b0; e_o = '0; e_s = 1'b0; cnt = 0;
    end else if (!e_busy && ld) begin
      minv(a, res_o, sc);
      res_s  = (sc >= 0);
      cnt    = res_s ? sc + 1 : LAT;
      e_busy = 1'b1; e_done = 1'b0; e_o = '0; e_s = 1'b0;
    end else if (e_busy) begin
      cnt--;
      if (cnt == 0) begin
        e_busy = 1'b0; e_done = 1'b1; e_o = res_o; e_s = res_s;
      end
    end else begin
      e_done = 1'b0;
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("singular", 64'(singular), 64'(e_s));
      chk("o", o, e_o);
      chk("err", 64'(err), 64'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse ld with m, wait (bounded) for done; returns cycles from ld edge to done.
  task automatic run(input logic [63:0] m, output int lat);
    int t;
    ld = 1'b1; a = m;
    tick();
    ld = 1'b0;
    t = 1;
    while (!done && t < 20) begin tick(); t++; end
    if (!done) chk("timeout", 64'(t), 64'(LAT + 1));
    lat = t - 1;
  endtask

  logic [63:0] mo;
  int          msc, lat;

  initial begin
    rst = 1'b1; ld = 1'b0; a = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("reset_o", o, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    minv(ID, mo, msc);
    chk("model_id", mo, ID);
    chk("model_id_sc", 64'(msc), 64'(-1));
    minv(64'h0102040810204080, mo, msc);
    chk("model_rev", mo, 64'h0102040810204080);
    minv(64'hFF7F3F1F0F070301, mo, msc);
    chk("model_utri", mo, 64'hC06030180C060301);
    minv(64'h0, mo, msc);
    chk("model_zero_sc", 64'(msc), 64'd0);
    minv(64'h8080808080808080, mo, msc);
    chk("model_col0_sc", 64'(msc), 64'd1);

    run(ID, lat);
    chk("id_o", o, ID);
    chk("id_lat", 64'(lat), 64'(LAT));
    tick();
    run(64'h0102040810204080, lat);
    chk("rev_o", o, 64'h0102040810204080);
    tick();
    run(64'hFF7F3F1F0F070301, lat);
    chk("utri_o", o, 64'hC06030180C060301);
    chk("utri_lat", 64'(lat), 64'(LAT));
    tick();
    run(64'h0, lat);
    chk("zero_sing", 64'(singular), 64'd1);
    chk("zero_lat", 64'(lat), 64'd1);
    tick();
    run(64'h8080808080808080, lat);
    chk("col0_sing", 64'(singular), 64'd1);
    chk("col0_lat", 64'(lat), 64'd2);
    tick();

    // ld pulses while busy are ignored.
    ld = 1'b1; a = 64'hFF7F3F1F0F070301;
    for (int t = 1; t < 20 && !done; t++) begin
      tick();
      ld = (t == 3 || t == 5);
      a  = ld ? 64'h0 : a;
    end
    ld = 1'b0;
    chk("ign_o", o, 64'hC06030180C060301);
    // ld in the done cycle is accepted.
    run(64'h0102040810204080, lat);
    chk("b2b_o", o, 64'h0102040810204080);
    chk("b2b_lat", 64'(lat), 64'(LAT));
    tick();

    // Reset mid-elimination, sampled at the column-4 edge.
    ld = 1'b1; a = ID;
    tick();
    ld = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_o", o, 64'd0);
    tick();
    run(64'hFF7F3F1F0F070301, lat);
    chk("post_rst_o", o, 64'hC06030180C060301);
    tick();

    for (int it = 0; it < 400; it++) begin
      ld  = ($urandom_range(2, 0) != 0);
      a   = ($urandom_range(1, 0) == 1) ? mk_inv() : {$urandom, $urandom};
      rst = ($urandom_range(60, 0) == 0);
      tick();
    end
    ld = 1'b0; rst = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
